misr_sig_checker: RTL and testbench

Downstream of the 3-bit MISR compaction stage. Checks the signature after a programmed observation window. Per run it pulses the MISR's clear input, counts a window of functional cycles, then samples the MISR value and compares it against a golden signature. Pass/fail and a saturating mismatch count go to the fault-campaign controller. This is the observation point for injected-error detection.

---
 rtl/misr_sig_checker_if.sv | 26 ++
 rtl/misr_sig_checker.sv | 72 +++++++
 tb/tb_misr_sig_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/misr_sig_checker_if.sv
// misr_sig_checker_if: control, MISR and result signals between the fault-campaign controller and the signature checker
interface misr_sig_checker_if #(
  parameter int MISR_W = 3,
  parameter int WIN_W = 4,
  parameter int CNT_W = 8
);
  logic start;
  logic [WIN_W-1:0] window_len;
  logic [MISR_W-1:0] golden;
  logic [MISR_W-1:0] misr_in;
  logic misr_rst;
  logic busy;
  logic done;
  logic match;
  logic mismatch;
  logic [MISR_W-1:0] sig_out;
  logic [CNT_W-1:0] mismatch_cnt;
  modport master (
    output start, window_len, golden, misr_in,
    input misr_rst, busy, done, match, mismatch, sig_out, mismatch_cnt
  );
  modport slave (
    input start, window_len, golden, misr_in,
    output misr_rst, busy, done, match, mismatch, sig_out, mismatch_cnt
  );
endinterface

// File: rtl/misr_sig_checker.sv
// misr_sig_checker: clears the MISR, waits a programmed window, then compares its signature with a golden value
module misr_sig_checker #(
  parameter int MISR_W = 3,
  parameter int WIN_W = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic m_rst_n,
  misr_sig_checker_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, COMPARE, DONE} state_t;
  state_t state;
  logic [WIN_W-1:0] cnt, win_q;
  logic [MISR_W-1:0] gold_q, sig_q;
  logic [CNT_W-1:0] err_cnt;
  logic misr_rst_q, busy_q, done_q, match_q, mismatch_q;
  assign bus.misr_rst = misr_rst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.match = match_q;
  assign bus.mismatch = mismatch_q;
  assign bus.sig_out = sig_q;
  assign bus.mismatch_cnt = err_cnt;
  // run sequencer; every output is a register so the MISR clear and result flags are glitch-free
  always_ff @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      win_q <= '0;
      gold_q <= '0;
      sig_q <= '0;
      err_cnt <= '0;
      misr_rst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      match_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          win_q <= bus.window_len;
          gold_q <= bus.golden;
          misr_rst_q <= 1'b1;
          busy_q <= 1'b1;
          done_q <= 1'b0;
          match_q <= 1'b0;
          mismatch_q <= 1'b0;
          state <= CLEAR;
        end
        CLEAR: begin
          cnt <= win_q;
          misr_rst_q <= 1'b0;
          state <= (win_q != '0) ? RUN : COMPARE;
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == WIN_W'(1)) state <= COMPARE;
        end
        COMPARE: begin
          sig_q <= bus.misr_in;
          match_q <= bus.misr_in == gold_q;
          mismatch_q <= bus.misr_in != gold_q;
          if (bus.misr_in != gold_q && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_misr_sig_checker.sv
// tb_misr_sig_checker: directed runs against two checkers (8-bit and 2-bit mismatch counters) with a queued scoreboard
module tb_misr_sig_checker;
  logic clk = 1'b0;
  logic m_rst_n;
  logic start;
  logic [3:0] wl;
  logic [2:0] gold;
  logic [2:0] m1 = 3'b001;
  logic [2:0] m2 = 3'b001;
  int tests = 0;
  int fails = 0;
  int e1 = 0;
  int e2 = 0;
  typedef struct {
    logic [2:0] sig;
    logic mt;
    logic [7:0] c1;
    logic [1:0] c2;
    int lat;
    int nb;
  } exp_t;
  exp_t q[$];
  misr_sig_checker_if #(.MISR_W(3), .WIN_W(4), .CNT_W(8)) b1 ();
  misr_sig_checker_if #(.MISR_W(3), .WIN_W(4), .CNT_W(2)) b2 ();
  misr_sig_checker #(.MISR_W(3), .WIN_W(4), .CNT_W(8)) u1 (.clk(clk), .m_rst_n(m_rst_n), .bus(b1));
  misr_sig_checker #(.MISR_W(3), .WIN_W(4), .CNT_W(2)) u2 (.clk(clk), .m_rst_n(m_rst_n), .bus(b2));
  assign b1.start = start;
  assign b1.window_len = wl;
  assign b1.golden = gold;
  assign b1.misr_in = m1;
  assign b2.start = start;
  assign b2.window_len = wl;
  assign b2.golden = gold;
  assign b2.misr_in = m2;
  always #5 clk = ~clk;
  function automatic logic [2:0] step(input logic [2:0] s);
    return {s[0] ^ s[2], s[2], s[1]};
  endfunction
  // MISR models with zero data inputs, seeded by each checker's clear pulse
  always @(posedge clk) begin
    m1 <= b1.misr_rst ? 3'b001 : step(m1);
    m2 <= b2.misr_rst ? 3'b001 : step(m2);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] w, input logic [2:0] g);
    exp_t e;
    logic [2:0] s;
    int k, nr, nb;
    s = 3'b001;
    for (int i = 0; i < int'(w); i++) s = step(s);
    if (s != g) begin
      e1 = (e1 == 255) ? 255 : e1 + 1;
      e2 = (e2 == 3) ? 3 : e2 + 1;
    end
    e.sig = s;
    e.mt = (s == g);
    e.c1 = 8'(e1);
    e.c2 = 2'(e2);
    e.lat = int'(w) + 3;
    e.nb = int'(w) + 2;
    q.push_back(e);
    @(negedge clk);
    wl = w;
    gold = g;
    start = 1'b1;
    k = 0;
    nr = 0;
    nb = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        wl = 4'($urandom);
        gold = 3'($urandom);
      end
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (b1.done) break;
      nr += int'(b1.misr_rst);
      nb += int'(b1.busy);
    end
    e = q.pop_front();
    chk("done_latency", k, e.lat);
    chk("misr_rst_cycles", nr, 1);
    chk("busy_cycles", nb, e.nb);
    chk("sig_out", b1.sig_out, e.sig);
    chk("match", b1.match, e.mt);
    chk("mismatch", b1.mismatch, !e.mt);
    chk("mismatch_cnt", b1.mismatch_cnt, e.c1);
    chk("done2", b2.done, 1);
    chk("sig_out2", b2.sig_out, e.sig);
    chk("mismatch_cnt2", b2.mismatch_cnt, e.c2);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk(tag, {b1.misr_rst, b1.busy, b1.done, b1.match, b1.mismatch, b1.sig_out, b1.mismatch_cnt,
              b2.mismatch_cnt}, 0);
  endtask
  initial begin
    logic [1:0] sat [5];
    sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    m_rst_n = 1'b0;
    start = 1'b0;
    wl = '0;
    gold = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    m_rst_n = 1'b1;
    run(4'd3, 3'b111);
    run(4'd2, 3'b011);
    run(4'd0, 3'b001);
    run(4'd4, 3'b011);
    run(4'd1, 3'b000);
    @(negedge clk);
    wl = 4'd5;
    gold = 3'b000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("misr_rst_in_clear", b1.misr_rst, 1);
    m_rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_in_clear");
    @(negedge clk);
    m_rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_reset", b1.busy, 1);
    m_rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_in_run");
    chk("state_idle", u1.state, 0);
    e1 = 0;
    e2 = 0;
    @(negedge clk);
    m_rst_n = 1'b1;
    run(4'd3, 3'b111);
    for (int i = 0; i < 5; i++) begin
      run(4'd1, 3'b010);
      chk("saturation", b2.mismatch_cnt, sat[i]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
